// File: rtl/cba_pkg.sv
// Shared definitions for the pipelined carry-bypass adder/subtractor.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package cba_pkg;

    // Operation select carried on the 'sub' input.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } cba_mode_e;

    // Number of pipeline stages, one per BLK-bit block.
    function automatic int cba_stages(input int width, input int blk);
        return width / blk;
    endfunction

    // Legal when the width splits evenly into at least two blocks.
    function automatic bit cba_params_ok(input int width, input int blk);
        return (blk > 0) && ((width % blk) == 0) && ((width / blk) >= 2);
    endfunction

endpackage

// File: rtl/skip_block.sv
// One BLK-bit ripple block with a carry-skip mux on its carry-out.
// Latency: combinational.
// Backpressure: none (pure logic, no handshake).
module skip_block
    import cba_pkg::*;
#(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           p_all,
    output logic           c_msb
);

    logic [BLK-1:0] w_p;
    logic [BLK-1:0] w_g;
    logic [BLK:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Ripple carry through the block, LSB first.
    always_comb begin
        w_c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    end

    assign sum   = w_p ^ w_c[BLK-1:0];
    assign p_all = &w_p;
    // When every bit propagates, the block carry-out is the carry-in itself.
    assign cout  = p_all ? cin : w_c[BLK];
    assign c_msb = w_c[BLK-1];

endmodule

// File: rtl/carry_bypass_pipe.sv
// Pipelined carry-bypass add/sub, one BLK-bit block per stage, elastic valid/ready.
// Latency: WIDTH/BLK cycles from acceptance to out_valid; 1 result/cycle sustained.
// Backpressure: ready chains combinationally from out_ready; bubbles collapse, in_ready low when full or in reset.
module carry_bypass_pipe
    import cba_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sub,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic                 overflow,
    output logic [WIDTH/BLK-1:0] bypass_mask
);

    localparam int S = cba_stages(WIDTH, BLK);

    if (!cba_params_ok(WIDTH, BLK)) begin : g_param_check
        $error("carry_bypass_pipe: WIDTH must be a multiple of BLK with at least two blocks");
    end

    logic [S-1:0]     w_v;
    logic [S-1:0]     w_ready;
    cba_mode_e        w_mode;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Operand b is inverted once at entry so later stages never see 'sub'.
    assign w_mode  = cba_mode_e'(sub);
    assign w_b_eff = (w_mode == MODE_SUB) ? ~b : b;
    assign w_c0    = cin ^ (w_mode == MODE_SUB);

    // A stage may load if it is empty or anything downstream can move.
    always_comb begin
        logic w_chain;
        w_chain = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            w_chain    = w_chain | ~w_v[k];
            w_ready[k] = w_chain;
        end
    end

    assign in_ready = w_ready[0] & ~rst;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int IN_W = WIDTH - k * BLK;  // operand bits not yet consumed
        localparam int LO_W = k * BLK;          // result bits already produced

        logic [IN_W-1:0]       w_a_in;
        logic [IN_W-1:0]       w_b_in;
        logic                  w_c_in;
        logic                  w_v_in;
        logic [BLK-1:0]        w_blk_sum;
        logic                  w_blk_cout;
        logic                  w_blk_p;
        logic                  w_cmsb;
        logic [LO_W+BLK-1:0]   w_sum_nx;
        logic [k:0]            w_mask_nx;

        logic                  r_v;
        logic                  r_c;
        logic [LO_W+BLK-1:0]   r_sum;
        logic [k:0]            r_mask;

        if (k == 0) begin : g_entry
            assign w_a_in    = a;
            assign w_b_in    = w_b_eff;
            assign w_c_in    = w_c0;
            assign w_v_in    = in_valid;
            assign w_sum_nx  = w_blk_sum;
            assign w_mask_nx = w_blk_p;
        end else begin : g_chain
            assign w_a_in    = g_stage[k-1].g_fwd.r_a;
            assign w_b_in    = g_stage[k-1].g_fwd.r_b;
            assign w_c_in    = g_stage[k-1].r_c;
            assign w_v_in    = g_stage[k-1].r_v;
            assign w_sum_nx  = {w_blk_sum, g_stage[k-1].r_sum};
            assign w_mask_nx = {w_blk_p, g_stage[k-1].r_mask};
        end

        skip_block #(
            .BLK (BLK)
        ) u_blk (
            .a     (w_a_in[BLK-1:0]),
            .b     (w_b_in[BLK-1:0]),
            .cin   (w_c_in),
            .sum   (w_blk_sum),
            .cout  (w_blk_cout),
            .p_all (w_blk_p),
            .c_msb (w_cmsb)
        );

        // Stage register: valid, block carry-out, accumulated sum and bypass mask.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v    <= 1'b0;
                r_c    <= 1'b0;
                r_sum  <= '0;
                r_mask <= '0;
            end else if (w_ready[k]) begin
                r_v    <= w_v_in;
                r_c    <= w_blk_cout;
                r_sum  <= w_sum_nx;
                r_mask <= w_mask_nx;
            end
        end

        assign w_v[k] = r_v;

        if (k < S - 1) begin : g_fwd
            localparam int HW = WIDTH - (k + 1) * BLK;
            logic [HW-1:0] r_a;
            logic [HW-1:0] r_b;
            // Carry-into-MSB only matters for the top block.
            logic          w_cmsb_unused;
            assign w_cmsb_unused = w_cmsb;

            // Forward the operand bits that later stages still need.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_ready[k]) begin
                    r_a <= w_a_in[IN_W-1:BLK];
                    r_b <= w_b_in[IN_W-1:BLK];
                end
            end
        end else begin : g_last
            logic r_ovf;
            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_ready[k]) begin
                    r_ovf <= w_cmsb ^ w_blk_cout;
                end
            end
        end
    end

    assign out_valid   = w_v[S-1];
    assign sum         = g_stage[S-1].r_sum;
    assign cout        = g_stage[S-1].r_c;
    assign overflow    = g_stage[S-1].g_last.r_ovf;
    assign bypass_mask = g_stage[S-1].r_mask;

endmodule

// File: tb/tb_carry_bypass_pipe.sv
// Directed and randomized bench for carry_bypass_pipe (WIDTH=32, BLK=8).
// Latency: checks 4-cycle acceptance-to-result timing.
// Backpressure: exercises stalls, bubbles and async reset mid-flight.
module tb_carry_bypass_pipe;

    localparam int WIDTH  = 32;
    localparam int BLK    = 8;
    localparam int S      = 4;
    localparam int N_RAND = 10000;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic [S-1:0]     m;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic [S-1:0]     bypass_mask;

    int n_cmp = 0;
    int n_bad = 0;

    carry_bypass_pipe #(
        .WIDTH (WIDTH),
        .BLK   (BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .cin         (cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow),
        .bypass_mask (bypass_mask)
    );

    always #5 clk = ~clk;

    // Golden model: plain integer add plus sign-rule overflow and per-block propagate.
    function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic ms, input logic mc);
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] x;
        logic [WIDTH:0]   full;
        res_t             r;
        bx   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bx} + (WIDTH+1)'(ms ^ mc);
        r.s  = full[WIDTH-1:0];
        r.co = full[WIDTH];
        r.ov = (ma[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        x    = ma ^ bx;
        for (int k = 0; k < S; k++) r.m[k] = &x[k*BLK +: BLK];
        return r;
    endfunction

    function automatic res_t obs();
        return {sum, cout, overflow, bypass_mask};
    endfunction

    // Let the pipe empty; starts and ends 1 time unit after a rising edge.
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 2) @(posedge clk);
        #1;
    endtask

    // Offer one operand to an empty pipe and wait (bounded) for its result.
    task automatic run_one(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic ts, input logic tc, output int lat, output res_t r);
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = obs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (obs() !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", obs()); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_wrap();
        int   lat;
        res_t r;
        res_t e;
        e = {32'h0000_0000, 1'b1, 1'b0, 4'b1111};
        run_one(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, lat, r);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL add_wrap_lat: got %0d want 4", lat); end
        n_cmp++; if (r !== e) begin n_bad++; $display("FAIL add_wrap_val: got %h want %h", r, e); end
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        logic             vs[4];
        logic             vc[4];
        res_t             ve[4];
        int               lat;
        res_t             r;
        va[0] = 32'h5;         vb[0] = 32'h7; vs[0] = 1'b1; vc[0] = 1'b0; ve[0] = {32'hFFFF_FFFE, 1'b0, 1'b0, 4'b1110};
        va[1] = 32'h8000_0000; vb[1] = 32'h1; vs[1] = 1'b1; vc[1] = 1'b0; ve[1] = {32'h7FFF_FFFF, 1'b1, 1'b1, 4'b0110};
        va[2] = 32'hA;         vb[2] = 32'h3; vs[2] = 1'b1; vc[2] = 1'b1; ve[2] = {32'h0000_0006, 1'b1, 1'b0, 4'b1110};
        va[3] = 32'h7FFF_FFFF; vb[3] = 32'h1; vs[3] = 1'b0; vc[3] = 1'b0; ve[3] = {32'h8000_0000, 1'b0, 1'b1, 4'b0110};
        for (int i = 0; i < 4; i++) begin
            run_one(va[i], vb[i], vs[i], vc[i], lat, r);
            n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL arith_lat[%0d]: got %0d want 4", i, lat); end
            n_cmp++; if (r !== ve[i]) begin n_bad++; $display("FAIL arith_val[%0d]: got %h want %h", i, r, ve[i]); end
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] oa[6];
        logic [WIDTH-1:0] ob[6];
        res_t             e[6];
        int               nacc = 0;
        int               ncons = 0;
        int               first_cons = 0;
        int               hold = 0;
        bit               stalled = 0;
        bit               saw_full = 0;
        drain();
        for (int i = 0; i < 6; i++) begin
            oa[i] = 32'h1357_9BDF + i * 32'h0102_0304;
            ob[i] = 32'h00FF_00FF * i;
            e[i]  = model(oa[i], ob[i], 1'b0, 1'b0);
        end
        sub = 1'b0; cin = 1'b0;
        for (int t = 0; t < 60 && ncons < 6; t++) begin
            in_valid = (nacc < 6);
            a = (nacc < 6) ? oa[nacc] : '0;
            b = (nacc < 6) ? ob[nacc] : '0;
            if (out_valid && !stalled) begin
                out_ready = 1'b0;
                stalled   = 1;
            end else if (stalled && hold >= 6) begin
                out_ready = 1'b1;
            end
            #1;
            if (stalled && !out_ready) begin
                hold++;
                if (!in_ready && !saw_full) begin
                    saw_full = 1;
                    n_cmp++; if (nacc !== 4) begin n_bad++; $display("FAIL stall_capacity: got %0d held want 4", nacc); end
                end
                n_cmp++; if (out_valid !== 1'b1 || obs() !== e[0]) begin
                    n_bad++; $display("FAIL stall_hold: got vld=%b %h want vld=1 %h", out_valid, obs(), e[0]);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++; if (obs() !== e[ncons]) begin n_bad++; $display("FAIL stall_order[%0d]: got %h want %h", ncons, obs(), e[ncons]); end
                if (ncons == 0) first_cons = t;
                else begin
                    n_cmp++; if (t !== first_cons + ncons) begin n_bad++; $display("FAIL stall_rate[%0d]: got cycle %0d want %0d", ncons, t, first_cons + ncons); end
                end
                ncons++;
            end
            if (in_valid && in_ready) nacc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (ncons !== 6) begin n_bad++; $display("FAIL stall_count: got %0d want 6", ncons); end
        n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL stall_full_seen: got %b want 1", saw_full); end
    endtask

    task automatic test_bubbles();
        logic [WIDTH-1:0] oa[4];
        logic [WIDTH-1:0] ob[4];
        res_t             e[4];
        int               acc_t[4];
        int               nacc = 0;
        int               ncons = 0;
        int               nvld = 0;
        drain();
        for (int i = 0; i < 4; i++) begin
            oa[i] = 32'hA5A5_0000 ^ (i * 32'h0003_1F07);
            ob[i] = 32'h5A5A_FFFF - i;
            e[i]  = model(oa[i], ob[i], 1'b0, 1'b1);
            acc_t[i] = 0;
        end
        sub = 1'b0; cin = 1'b1;
        for (int t = 0; t < 30; t++) begin
            in_valid = ((t % 2) == 0) && (nacc < 4);
            a = oa[nacc % 4];
            b = ob[nacc % 4];
            #1;
            if (out_valid) begin
                nvld++;
                if (ncons < 4) begin
                    n_cmp++; if (obs() !== e[ncons]) begin n_bad++; $display("FAIL bubble_val[%0d]: got %h want %h", ncons, obs(), e[ncons]); end
                    n_cmp++; if (t - acc_t[ncons] !== 4) begin n_bad++; $display("FAIL bubble_lat[%0d]: got %0d want 4", ncons, t - acc_t[ncons]); end
                    ncons++;
                end
            end
            if (in_valid && in_ready) begin
                acc_t[nacc] = t;
                nacc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (nvld !== 4) begin n_bad++; $display("FAIL bubble_count: got %0d want 4", nvld); end
    endtask

    task automatic test_async_reset();
        int   lat;
        int   nvld = 0;
        res_t r;
        res_t e;
        drain();
        out_ready = 1'b0; sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h0000_1000 * (i + 1);
            b = 32'h0000_0010;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_loaded: got %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (obs() !== '0) begin n_bad++; $display("FAIL arst_data: got %h want 0", obs()); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 8; t++) begin
            if (out_valid) nvld++;
            @(posedge clk); #1;
        end
        n_cmp++; if (nvld !== 0) begin n_bad++; $display("FAIL arst_stale: got %0d valid cycles want 0", nvld); end
        e = model(32'h0BAD_F00D, 32'h1234_5678, 1'b1, 1'b0);
        run_one(32'h0BAD_F00D, 32'h1234_5678, 1'b1, 1'b0, lat, r);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL arst_after_lat: got %0d want 4", lat); end
        n_cmp++; if (r !== e) begin n_bad++; $display("FAIL arst_after_val: got %h want %h", r, e); end
    endtask

    task automatic test_random();
        res_t             q[$];
        res_t             cur;
        res_t             prev;
        res_t             e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        logic             rc;
        int               sent = 0;
        int               got = 0;
        bit               pend = 0;
        bit               prev_stall = 0;
        cur  = '0;
        prev = '0;
        drain();
        for (int t = 0; t < 80000 && got < N_RAND; t++) begin
            if (pend) begin
                in_valid = 1'b0;
                pend = 0;
            end
            if (prev_stall) begin
                n_cmp++; if (out_valid !== 1'b1 || obs() !== prev) begin
                    n_bad++; $display("FAIL rand_hold: got vld=%b %h want vld=1 %h", out_valid, obs(), prev);
                end
            end
            if (!in_valid && sent < N_RAND && $urandom_range(0, 4) != 0) begin
                ra = $urandom;
                rs = 1'($urandom_range(0, 1));
                rc = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin
                    rb = rs ? ra : ~ra;
                    for (int k = 0; k < S; k++)
                        if ($urandom_range(0, 1) == 1) rb[k*BLK +: BLK] = 8'($urandom);
                end else begin
                    rb = $urandom;
                end
                a = ra; b = rb; sub = rs; cin = rc;
                cur = model(ra, rb, rs, rc);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            prev_stall = out_valid && !out_ready;
            prev = obs();
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rand_spurious: got %h want no result", obs());
                end else begin
                    e = q.pop_front();
                    n_cmp++; if (obs() !== e) begin n_bad++; $display("FAIL rand_val[%0d]: got %h want %h", got, obs(), e); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                pend = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (got !== N_RAND || q.size() !== 0) begin
            n_bad++; $display("FAIL rand_count: got %0d results %0d pending want %0d results 0 pending", got, q.size(), N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub();
        test_stall();
        test_bubbles();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
